mult_sequencer: RTL and testbench

//  Execute-stage controller for the shared iterative multiplier. Launches a

---
 rtl/mult_sequencer_pkg.sv | 6 +
 rtl/mult_watchdog.sv | 20 ++
 rtl/mult_sequencer.sv | 99 +++++++++
 tb/tb_mult_sequencer.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/mult_sequencer_pkg.sv
// mult_sequencer_pkg: shared FSM encoding and default sizing for the multiply sequencer
package mult_sequencer_pkg;
   typedef enum logic [1:0] {IDLE, LAUNCH, BUSY} mult_state_t;
   localparam int WIDTH_DEF   = 32;
   localparam int TIMEOUT_DEF = 40;
endpackage

// File: rtl/mult_watchdog.sv
// mult_watchdog: clearable up-counter whose terminal flag marks the last allowed BUSY cycle
//   ports: clk, reset (sync, active-high), clr (zero the count), en (count up),
//          tc (count has reached TIMEOUT-1, so the next increment would hit TIMEOUT)
module mult_watchdog #(
   parameter int TIMEOUT = 40
) (
   input  logic clk,
   input  logic reset,
   input  logic clr,
   input  logic en,
   output logic tc
);
   localparam int CW = $clog2(TIMEOUT + 1);
   logic [CW-1:0] count;
   always_ff @(posedge clk) begin
      if (reset || clr) count <= '0;
      else if (en) count <= count + CW'(1);
   end
   assign tc = (count == CW'(TIMEOUT - 1));
endmodule

// File: rtl/mult_sequencer.sv
// mult_sequencer: E-stage controller for the shared iterative multiplier, owning HI/LO
//   inputs : clk, reset (sync, active-high), mult_req_e, mult_sign_e, srca_e, srcb_e,
//            mfhi_d, mflo_d, mult_ready, mult_done, product
//   outputs: start_mult, mult_sign, op_a, op_b, hi, lo, stall_req, busy, protocol_err
//   option : HILO_BYPASS_EN forwards the product onto hi/lo in the done cycle and
//            releases the MFHI/MFLO stall one cycle earlier
module mult_sequencer
   import mult_sequencer_pkg::*;
#(
   parameter int WIDTH   = WIDTH_DEF,
   parameter int TIMEOUT = TIMEOUT_DEF
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               mult_req_e,
   input  logic               mult_sign_e,
   input  logic [WIDTH-1:0]   srca_e,
   input  logic [WIDTH-1:0]   srcb_e,
   input  logic               mfhi_d,
   input  logic               mflo_d,
   input  logic               mult_ready,
   input  logic               mult_done,
   input  logic [2*WIDTH-1:0] product,
   output logic               start_mult,
   output logic               mult_sign,
   output logic [WIDTH-1:0]   op_a,
   output logic [WIDTH-1:0]   op_b,
   output logic [WIDTH-1:0]   hi,
   output logic [WIDTH-1:0]   lo,
   output logic               stall_req,
   output logic               busy,
   output logic               protocol_err
);
   mult_state_t state, state_nx;
   logic [WIDTH-1:0] hi_q, lo_q;
   logic accept, done_ok, wd_tc, timeout, spurious, hilo_wait;

   mult_watchdog #(.TIMEOUT(TIMEOUT)) u_wd (
      .clk  (clk),
      .reset(reset),
      .clr  (state == LAUNCH),
      .en   (state == BUSY),
      .tc   (wd_tc)
   );

   assign accept   = (state == IDLE) && mult_req_e && mult_ready;
   assign done_ok  = (state == BUSY) && mult_done;
   assign timeout  = (state == BUSY) && !mult_done && wd_tc;
   assign spurious = (state != BUSY) && mult_done;

`ifdef HILO_BYPASS_EN
   assign hi        = done_ok ? product[2*WIDTH-1:WIDTH] : hi_q;
   assign lo        = done_ok ? product[WIDTH-1:0] : lo_q;
   assign hilo_wait = (state != IDLE) && !done_ok;
`else
   assign hi        = hi_q;
   assign lo        = lo_q;
   assign hilo_wait = (state != IDLE);
`endif

   always_comb begin
      state_nx   = state;
      start_mult = 1'b0;
      busy       = 1'b0;
      stall_req  = 1'b0;
      state_nx   = (state == IDLE)   ? (accept ? LAUNCH : IDLE) :
                   (state == LAUNCH) ? BUSY :
                   ((mult_done || wd_tc) ? IDLE : BUSY);
      start_mult = (state == LAUNCH);
      busy       = (state != IDLE);
      // a waiting E-stage request is held, never dropped, until accepted in IDLE
      stall_req  = ((mfhi_d || mflo_d) && hilo_wait) ||
                   (mult_req_e && ((state != IDLE) || !mult_ready));
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state        <= IDLE;
         mult_sign    <= 1'b0;
         op_a         <= '0;
         op_b         <= '0;
         hi_q         <= '0;
         lo_q         <= '0;
         protocol_err <= 1'b0;
      end else begin
         state <= state_nx;
         if (accept) begin
            op_a      <= srca_e;
            op_b      <= srcb_e;
            mult_sign <= mult_sign_e;
         end
         if (done_ok) begin
            hi_q <= product[2*WIDTH-1:WIDTH];
            lo_q <= product[WIDTH-1:0];
         end
         if (timeout || spurious) protocol_err <= 1'b1;
      end
   end
endmodule

// File: tb/tb_mult_sequencer.sv
// tb_mult_sequencer: directed self-checking bench for mult_sequencer
module tb_mult_sequencer;
   localparam int W   = 32;
   localparam int TMO = 40;
`ifdef HILO_BYPASS_EN
   localparam bit BYP = 1'b1;
`else
   localparam bit BYP = 1'b0;
`endif

   logic           clk, reset;
   logic           mult_req_e, mult_sign_e, mfhi_d, mflo_d, mult_ready, mult_done;
   logic [W-1:0]   srca_e, srcb_e;
   logic [2*W-1:0] product;
   logic           start_mult, mult_sign, stall_req, busy, protocol_err;
   logic [W-1:0]   op_a, op_b, hi, lo;
   int             checks = 0;
   int             errors = 0;

   mult_sequencer #(.WIDTH(W), .TIMEOUT(TMO)) dut (
      .clk         (clk),
      .reset       (reset),
      .mult_req_e  (mult_req_e),
      .mult_sign_e (mult_sign_e),
      .srca_e      (srca_e),
      .srcb_e      (srcb_e),
      .mfhi_d      (mfhi_d),
      .mflo_d      (mflo_d),
      .mult_ready  (mult_ready),
      .mult_done   (mult_done),
      .product     (product),
      .start_mult  (start_mult),
      .mult_sign   (mult_sign),
      .op_a        (op_a),
      .op_b        (op_b),
      .hi          (hi),
      .lo          (lo),
      .stall_req   (stall_req),
      .busy        (busy),
      .protocol_err(protocol_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic step;
      @(posedge clk);
      #1;
   endtask

   // request accepted at the next edge; returns in the first BUSY cycle
   task automatic launch(input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
      mult_req_e = 1'b1; srca_e = a; srcb_e = b; mult_sign_e = s;
      #1 check("accept_stall", stall_req, 0);
      step;
      mult_req_e = 1'b0; srca_e = 32'hDEAD_BEEF; srcb_e = 32'h1234_5678; mult_sign_e = ~s;
      #1;
      check("start_pulse", start_mult, 1);
      check("op_a", op_a, a);
      check("op_b", op_b, b);
      check("sign", mult_sign, s);
      step;
      check("start_once", start_mult, 0);
      check("busy", busy, 1);
   endtask

   task automatic finish_mult(input logic [2*W-1:0] p, input logic [W-1:0] ehi, input logic [W-1:0] elo);
      product = p; mult_done = 1'b1;
      #1 check("busy_done_cyc", busy, 1);
      step;
      mult_done = 1'b0; product = '0;
      #1;
      check("hi", hi, ehi);
      check("lo", lo, elo);
      check("idle_after_done", busy, 0);
      check("no_start", start_mult, 0);
   endtask

   initial begin
      reset = 1'b1; mult_req_e = 0; mult_sign_e = 0; mfhi_d = 0; mflo_d = 0;
      mult_ready = 1; mult_done = 0; srca_e = '0; srcb_e = '0; product = '0;
      step; step;
      reset = 1'b0;
      #1;
      check("rst_busy", busy, 0);
      check("rst_stall", stall_req, 0);
      check("rst_start", start_mult, 0);
      check("rst_hi", hi, 0);
      check("rst_lo", lo, 0);
      check("rst_err", protocol_err, 0);
      check("rst_opa", op_a, 0);

      // signed -3 x 5
      launch(32'hFFFF_FFFD, 32'd5, 1'b1);
      step; step;
      finish_mult(64'hFFFF_FFFF_FFFF_FFF1, 32'hFFFF_FFFF, 32'hFFFF_FFF1);

      // unsigned FFFFFFFF x 2
      launch(32'hFFFF_FFFF, 32'd2, 1'b0);
      step;
      finish_mult(64'h0000_0001_FFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFE);

      // MFHI in D two cycles after launch
      launch(32'd2, 32'd3, 1'b0);
      step;
      mfhi_d = 1'b1;
      #1 check("mfhi_stall_b2", stall_req, 1);
      step;
      check("mfhi_stall_b3", stall_req, 1);
      product = 64'h0000_000A_0000_0006; mult_done = 1'b1;
      #1;
      check("mfhi_stall_done", stall_req, !BYP);
      check("hi_done_cyc", hi, BYP ? 32'h0000_000A : 32'h0000_0001);
      step;
      mult_done = 1'b0;
      #1;
      check("mfhi_release", stall_req, 0);
      check("mfhi_reads_new", hi, 32'h0000_000A);
      mfhi_d = 1'b0;

      // back-to-back: second request arrives during BUSY
      launch(32'd7, 32'd6, 1'b0);
      mult_req_e = 1'b1; srca_e = 32'd3; srcb_e = 32'd4; mult_sign_e = 1'b0;
      #1 check("b2b_stall_busy", stall_req, 1);
      step;
      product = 64'd42; mult_done = 1'b1;
      #1;
      check("b2b_stall_done", stall_req, 1);
      check("b2b_no_start", start_mult, 0);
      step;
      mult_done = 1'b0;
      #1;
      check("b2b_lo1", lo, 42);
      check("b2b_hi1", hi, 0);
      check("b2b_idle_nostall", stall_req, 0);
      check("b2b_idle_nostart", start_mult, 0);
      step;
      mult_req_e = 1'b0;
      #1;
      check("b2b_start2", start_mult, 1);
      check("b2b_opa2", op_a, 3);
      check("b2b_opb2", op_b, 4);
      step;
      check("b2b_lo_kept", lo, 42);
      finish_mult(64'd12, 32'd0, 32'd12);

      // multiplier not ready: request stalls and waits in IDLE
      mult_ready = 1'b0; mult_req_e = 1'b1; srca_e = 32'd9; srcb_e = 32'd9;
      #1 check("nr_stall", stall_req, 1);
      step;
      check("nr_idle", busy, 0);
      mult_ready = 1'b1;
      #1 check("nr_release", stall_req, 0);
      step;
      mult_req_e = 1'b0;
      #1;
      check("nr_start", start_mult, 1);
      check("nr_opa", op_a, 9);
      step;
      finish_mult(64'd81, 32'd0, 32'd81);

      // timeout: done withheld
      launch(32'd5, 32'd5, 1'b0);
      repeat (TMO - 1) step;
      check("tmo_still_busy", busy, 1);
      check("tmo_no_err_yet", protocol_err, 0);
      step;
      check("tmo_idle", busy, 0);
      check("tmo_err", protocol_err, 1);
      check("tmo_lo_kept", lo, 81);
      check("tmo_hi_kept", hi, 0);
      step;
      check("err_sticky", protocol_err, 1);
      reset = 1'b1;
      step;
      reset = 1'b0;
      #1 check("err_cleared", protocol_err, 0);

      // spurious done in IDLE
      product = 64'hAAAA_AAAA_5555_5555; mult_done = 1'b1;
      step;
      mult_done = 1'b0;
      #1;
      check("spur_err", protocol_err, 1);
      check("spur_lo", lo, 0);
      check("spur_hi", hi, 0);

      // reset during BUSY, late done while reset is held
      reset = 1'b1; step; reset = 1'b0;
      launch(32'd4, 32'd4, 1'b0);
      finish_mult(64'h0000_0003_0000_0010, 32'd3, 32'h10);
      launch(32'd1, 32'd1, 1'b1);
      reset = 1'b1;
      step;
      product = '1; mult_done = 1'b1;
      step;
      mult_done = 1'b0; reset = 1'b0;
      #1;
      check("r6_busy", busy, 0);
      check("r6_hi", hi, 0);
      check("r6_lo", lo, 0);
      check("r6_sign", mult_sign, 0);
      check("r6_opa", op_a, 0);
      check("r6_err", protocol_err, 0);
      check("r6_start", start_mult, 0);
      step;
      check("r6_no_capture", lo, 0);
      check("r6_stall", stall_req, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
